// File: rtl/lvds_rx_arbiter_if.sv
// Write-side bundle between the two lvds_rx deframers, the capture arbiter and the RX FIFO.
// The arbiter uses the slave modport; the deframer/FIFO side uses master.
interface lvds_rx_arbiter_if;
    logic        i_ch0_push;
    logic [31:0] i_ch0_data;
    logic        i_ch1_push;
    logic [31:0] i_ch1_data;
    logic        i_fifo_full;
    logic        o_fifo_push;
    logic [31:0] o_fifo_data;

    modport master (
        output i_ch0_push, i_ch0_data, i_ch1_push, i_ch1_data, i_fifo_full,
        input  o_fifo_push, o_fifo_data
    );

    modport slave (
        input  i_ch0_push, i_ch0_data, i_ch1_push, i_ch1_data, i_fifo_full,
        output o_fifo_push, o_fifo_data
    );
endinterface

// File: rtl/lvds_rx_arbiter.sv
// Capture sequencer and two-channel round-robin arbiter feeding the 32-bit RX FIFO (i_ddr_clk domain).
// Optional LVDS_RX_ARB_STATS_EN adds saturating per-channel dropped-word counters.
module lvds_rx_arbiter #(
    parameter int unsigned BURST_W = 16,
    parameter bit          TAG_CH  = 1'b1
) (
    input  logic               i_ddr_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_ch_enable,
    input  logic [BURST_W-1:0] i_burst_len,
    lvds_rx_arbiter_if.slave   rx,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_overflow,
    output logic [1:0]         o_state
`ifdef LVDS_RX_ARB_STATS_EN
    ,
    output logic [15:0]        o_drop_cnt0,
    output logic [15:0]        o_drop_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               hold0_v_q, hold0_v_d, hold1_v_q, hold1_v_d;
    logic [31:0]        hold0_q, hold0_d, hold1_q, hold1_d;
    logic               rr_q, rr_d;
    logic [BURST_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               push_q, push_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic [1:0]         ovf_q, ovf_d;
    logic               gnt_v, gnt_ch, acc0, acc1, lost0, lost1, burst_end;
    logic [31:0]        gnt_word;
`ifdef LVDS_RX_ARB_STATS_EN
    logic [15:0]        drop0_q, drop0_d, drop1_q, drop1_d;
`endif

    always_comb begin
        // rr_q holds the channel preferred on contention, i.e. the one not granted last
        gnt_v  = 1'b0;
        gnt_ch = 1'b0;
        if (state_q != IDLE && !rx.i_fifo_full) begin
            if (hold0_v_q && hold1_v_q) begin
                gnt_v  = 1'b1;
                gnt_ch = rr_q;
            end else if (hold0_v_q) begin
                gnt_v  = 1'b1;
            end else if (hold1_v_q) begin
                gnt_v  = 1'b1;
                gnt_ch = 1'b1;
            end
        end
        gnt_word  = gnt_ch ? hold1_q : hold0_q;
        acc0      = (state_q == RUN) && i_ch_enable[0] && rx.i_ch0_push;
        acc1      = (state_q == RUN) && i_ch_enable[1] && rx.i_ch1_push;
        lost0     = acc0 && hold0_v_q && !(gnt_v && !gnt_ch);
        lost1     = acc1 && hold1_v_q && !(gnt_v && gnt_ch);
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        burst_end = (state_q == RUN) && gnt_v && (i_burst_len != '0) && (cnt_inc == i_burst_len);

        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        push_d    = gnt_v;
        data_d    = data_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q | {lost1, lost0};
        hold0_v_d = hold0_v_q;
        hold0_d   = hold0_q;
        hold1_v_d = hold1_v_q;
        hold1_d   = hold1_q;
`ifdef LVDS_RX_ARB_STATS_EN
        drop0_d   = drop0_q + {15'd0, lost0 && !(&drop0_q)};
        drop1_d   = drop1_q + {15'd0, lost1 && !(&drop1_q)};
`endif

        if (gnt_v) begin
            data_d = TAG_CH ? {gnt_ch, gnt_word[30:0]} : gnt_word;
            cnt_d  = cnt_inc;
            rr_d   = ~gnt_ch;
            if (gnt_ch) hold1_v_d = 1'b0;
            else        hold0_v_d = 1'b0;
        end
        if (acc0 && !lost0) begin
            hold0_v_d = 1'b1;
            hold0_d   = rx.i_ch0_data;
        end
        if (acc1 && !lost1) begin
            hold1_v_d = 1'b1;
            hold1_d   = rx.i_ch1_data;
        end

        case (state_q)
            IDLE: begin
                if (i_start && |i_ch_enable) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ovf_d   = '0;
`ifdef LVDS_RX_ARB_STATS_EN
                    drop0_d = '0;
                    drop1_d = '0;
`endif
                end
            end
            RUN: begin
                if (burst_end) begin
                    state_d   = IDLE;
                    hold0_v_d = 1'b0;
                    hold1_v_d = 1'b0;
                    done_d    = 1'b1;
                end else if (i_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold0_v_q && !hold1_v_q && !push_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            hold0_v_q <= 1'b0;
            hold0_q   <= '0;
            hold1_v_q <= 1'b0;
            hold1_q   <= '0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            push_q    <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= '0;
`ifdef LVDS_RX_ARB_STATS_EN
            drop0_q   <= '0;
            drop1_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hold0_v_q <= hold0_v_d;
            hold0_q   <= hold0_d;
            hold1_v_q <= hold1_v_d;
            hold1_q   <= hold1_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            push_q    <= push_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef LVDS_RX_ARB_STATS_EN
            drop0_q   <= drop0_d;
            drop1_q   <= drop1_d;
`endif
        end
    end

    assign rx.o_fifo_push = push_q;
    assign rx.o_fifo_data = data_q;
    assign o_busy         = (state_q == RUN) || (state_q == DRAIN);
    assign o_done         = done_q;
    assign o_overflow     = ovf_q;
    assign o_state        = state_q;
`ifdef LVDS_RX_ARB_STATS_EN
    assign o_drop_cnt0    = drop0_q;
    assign o_drop_cnt1    = drop1_q;
`endif

endmodule

// File: tb/tb_lvds_rx_arbiter.sv
// Directed-plus-random bench for lvds_rx_arbiter; expected FIFO writes come from a word-level queue model.
// Define LVDS_RX_ARB_STATS_EN to also exercise the dropped-word counters.
module tb_lvds_rx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  en = 2'b00;
    logic [15:0] blen = '0;
    logic        busy, done;
    logic [1:0]  ovf, st;
`ifdef LVDS_RX_ARB_STATS_EN
    logic [15:0] dc0, dc1;
`endif

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] got_d[$];
    int          got_c[$];
    int          done_c[$];
    logic [31:0] exp_d[$];
    int          exp_c[$];
    logic        last_g;

    lvds_rx_arbiter_if rx();

    lvds_rx_arbiter #(.BURST_W(16), .TAG_CH(1'b1)) dut (
        .i_ddr_clk  (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_ch_enable(en),
        .i_burst_len(blen),
        .rx         (rx),
        .o_busy     (busy),
        .o_done     (done),
        .o_overflow (ovf),
        .o_state    (st)
`ifdef LVDS_RX_ARB_STATS_EN
        ,
        .o_drop_cnt0(dc0),
        .o_drop_cnt1(dc1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (rx.o_fifo_push) begin
                got_d.push_back(rx.o_fifo_data);
                got_c.push_back(cyc);
            end
            if (done) done_c.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        got_d.delete(); got_c.delete(); done_c.delete();
        exp_d.delete(); exp_c.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc_n(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc_n(1); stop = 1'b0;
    endtask

    task automatic push(input logic p0, input logic [31:0] d0, input logic p1, input logic [31:0] d1);
        rx.i_ch0_push = p0; rx.i_ch0_data = d0;
        rx.i_ch1_push = p1; rx.i_ch1_data = d1;
        cyc_n(1);
        rx.i_ch0_push = 1'b0; rx.i_ch1_push = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (done_c.size() == 0 && k < lim) begin
            cyc_n(1);
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc_n(2); rst = 1'b0;
        last_g = 1'b1;
        clear_q();
    endtask

    // Word as it must appear on the FIFO: bit 31 carries the source channel
    function automatic logic [31:0] tag_w(input logic ch, input logic [31:0] w);
        return {ch, w[30:0]};
    endfunction

    task automatic check_pushes(input string tag);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            if (exp_c[i] >= 0) chk($sformatf("%s_cyc%0d", tag, i), got_c[i], exp_c[i]);
        end
    endtask

    initial begin
        logic [31:0] w, a, b, x, y;
        logic        first;
        int          c, len;

        rx.i_ch0_push = 1'b0; rx.i_ch0_data = '0;
        rx.i_ch1_push = 1'b0; rx.i_ch1_data = '0;
        rx.i_fifo_full = 1'b0;
        last_g = 1'b1;
        cyc_n(3);
        chk("rst_state", st, 2'b00);
        chk("rst_push", rx.o_fifo_push, 1'b0);
        chk("rst_data", rx.o_fifo_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 2'b00);
        rst = 1'b0;
        cyc_n(2);

        en = 2'b00; pulse_start();
        chk("start_no_enable", st, 2'b00);

        // Burst of 4 on ch0, words 16 cycles apart
        clear_q();
        en = 2'b01; blen = 16'd4;
        pulse_start();
        chk("t1_run", st, 2'b01);
        chk("t1_busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            w = $urandom; c = cyc;
            push(1'b1, w, 1'b0, '0);
            exp_d.push_back(tag_w(1'b0, w)); exp_c.push_back(c + 2);
            last_g = 1'b0;
            cyc_n(15);
        end
        check_pushes("t1");
        chk("t1_done_cnt", done_c.size(), 1);
        if (done_c.size() > 0) chk("t1_done_cyc", done_c[0], exp_c[3]);
        chk("t1_idle", st, 2'b00);
        push(1'b1, $urandom, 1'b0, '0);
        cyc_n(5);
        chk("t1_idle_ignored", got_d.size(), 4);

        // Random burst length, two surplus words after the burst completes
        clear_q();
        len = $urandom_range(2, 5);
        blen = 16'(len);
        pulse_start();
        for (int k = 0; k < len + 2; k++) begin
            w = $urandom; c = cyc;
            push(1'b1, w, 1'b0, '0);
            if (k < len) begin
                exp_d.push_back(tag_w(1'b0, w)); exp_c.push_back(c + 2);
                last_g = 1'b0;
            end
            cyc_n(5);
        end
        check_pushes("t1b");
        chk("t1b_done_cnt", done_c.size(), 1);
        if (done_c.size() > 0) chk("t1b_done_cyc", done_c[0], exp_c[len-1]);
        chk("t1b_idle", st, 2'b00);

        // Both channels push together, continuous mode
        do_reset();
        en = 2'b11; blen = '0;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            a = $urandom; b = $urandom; c = cyc;
            push(1'b1, a, 1'b1, b);
            first = ~last_g;
            exp_d.push_back(tag_w(first, first ? b : a)); exp_c.push_back(c + 2);
            exp_d.push_back(tag_w(~first, first ? a : b)); exp_c.push_back(c + 3);
            last_g = ~first;
            cyc_n(7);
        end
        chk("t2_ovf", ovf, 2'b00);
        pulse_stop();
        wait_done(20);
        check_pushes("t2");
        chk("t2_done_cnt", done_c.size(), 1);
        chk("t2_idle", st, 2'b00);

        // FIFO full: one word held, the next dropped
        clear_q();
        en = 2'b01; blen = '0;
        start = 1'b1; stop = 1'b1; cyc_n(1); start = 1'b0; stop = 1'b0;
        chk("t3_start_wins", st, 2'b01);
        rx.i_fifo_full = 1'b1;
        cyc_n(3);
        a = $urandom; push(1'b1, a, 1'b0, '0);
        cyc_n(15);
        b = $urandom; push(1'b1, b, 1'b0, '0);
        cyc_n(20);
        chk("t3_no_push_full", got_d.size(), 0);
        chk("t3_ovf", ovf, 2'b01);
        c = cyc;
        rx.i_fifo_full = 1'b0;
        exp_d.push_back(tag_w(1'b0, a)); exp_c.push_back(c + 1);
        last_g = 1'b0;
        cyc_n(5);
        check_pushes("t3");
        pulse_start();
        chk("t3_start_in_run", st, 2'b01);
        chk("t3_ovf_kept", ovf, 2'b01);
        pulse_stop();
        wait_done(20);
        chk("t3_idle", st, 2'b00);
        chk("t3_ovf_sticky", ovf, 2'b01);

        // Stop with both holds full behind a full FIFO
        clear_q();
        en = 2'b11;
        rx.i_fifo_full = 1'b1;
        pulse_start();
        chk("t4_ovf_clr", ovf, 2'b00);
        a = $urandom; b = $urandom;
        push(1'b1, a, 1'b1, b);
        cyc_n(4);
        pulse_stop();
        chk("t4_drain", st, 2'b10);
        chk("t4_busy", busy, 1'b1);
        x = $urandom; y = $urandom;
        push(1'b1, x, 1'b1, y);
        cyc_n(3);
        chk("t4_no_push_full", got_d.size(), 0);
        chk("t4_drain_ignores", ovf, 2'b00);
        c = cyc;
        rx.i_fifo_full = 1'b0;
        first = ~last_g;
        exp_d.push_back(tag_w(first, first ? b : a)); exp_c.push_back(c + 1);
        exp_d.push_back(tag_w(~first, first ? a : b)); exp_c.push_back(c + 2);
        last_g = ~first;
        wait_done(20);
        check_pushes("t4");
        chk("t4_done_cnt", done_c.size(), 1);
        chk("t4_idle", st, 2'b00);

        // Reset in RUN with holds full
        clear_q();
        en = 2'b11;
        rx.i_fifo_full = 1'b1;
        pulse_start();
        push(1'b1, $urandom, 1'b1, $urandom);
        cyc_n(2);
        push(1'b1, $urandom, 1'b0, '0);
        cyc_n(2);
        chk("t5_run", st, 2'b01);
        chk("t5_ovf_pre", ovf, 2'b01);
        rst = 1'b1;
        cyc_n(1);
        chk("t5_state", st, 2'b00);
        chk("t5_push", rx.o_fifo_push, 1'b0);
        chk("t5_data", rx.o_fifo_data, 32'h0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_ovf", ovf, 2'b00);
        rst = 1'b0;
        last_g = 1'b1;
        rx.i_fifo_full = 1'b0;
        cyc_n(10);
        chk("t5_no_push", got_d.size(), 0);
        chk("t5_no_done", done_c.size(), 0);

`ifdef LVDS_RX_ARB_STATS_EN
        // Five ch1 words lost behind a full hold
        clear_q();
        en = 2'b10;
        rx.i_fifo_full = 1'b1;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            push(1'b0, '0, 1'b1, $urandom);
            cyc_n(1);
        end
        chk("t6_drop1", dc1, 16'd5);
        chk("t6_drop0", dc0, 16'd0);
        chk("t6_ovf", ovf, 2'b10);
        pulse_stop();
        rx.i_fifo_full = 1'b0;
        wait_done(20);
        chk("t6_one_push", got_d.size(), 1);
        chk("t6_drop1_idle", dc1, 16'd5);
        clear_q();
        pulse_start();
        chk("t6_drop1_clr", dc1, 16'd0);
        pulse_stop();
        wait_done(20);
        chk("t6_idle", st, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
